mem_arbiter: RTL and testbench

- Sequences and shares the single unified instruction/data memory between the multicycle core's fetch path (IF port) and load/store path (LS port).
- Sits between the control unit/datapath and the memory: one access in flight at a time, fixed 3-cycle access slot, registered responses.
- Fairness counter prevents fetch starvation; range, alignment and instruction-region write protection are checked before any memory access.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified memory bus around mem_arbiter.
// The arbiter uses the slave view; requesters and memory models use the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_RD,
    output if_ready, if_rdata, if_err, ls_ready, ls_rdata, ls_err,
           mem_A, mem_WD, mem_WE
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_RD,
    input  if_ready, if_rdata, if_err, ls_ready, ls_rdata, ls_err,
           mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one unified memory between the fetch and load/store paths: one access at a
// time in a fixed IDLE/GRANT/RESP slot, with a wait counter that keeps fetch from starving.
module mem_arbiter #(
  parameter int MEM_WORDS = 1000,
  parameter int DATA_BASE = 2000,
  parameter int MAX_WAIT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
  localparam logic [31:0] DATA_START = 32'(DATA_BASE);
  localparam logic [3:0]  WAIT_MAX   = 4'(MAX_WAIT);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic        lat_fault;
  logic        owner_ls;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;

  logic        any_req;
  logic        pick_ls;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        sel_fault;
  logic [31:0] grant_rdata;

  // LS wins a contested slot until IF has been passed over MAX_WAIT times in a row.
  always_comb begin
    any_req   = bus.if_req | bus.ls_req;
    pick_ls   = bus.ls_req & (~bus.if_req | (wait_cnt < WAIT_MAX));
    sel_addr  = pick_ls ? bus.ls_addr : bus.if_addr;
    sel_we    = pick_ls & bus.ls_we;
    sel_fault = (sel_addr[1:0] != 2'b00) ||
                (sel_addr >= ADDR_LIMIT) ||
                (sel_we && (sel_addr < DATA_START));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stores and faulted accesses return zero instead of whatever the memory drives.
  assign grant_rdata = (lat_fault | lat_we) ? 32'h0 : bus.mem_RD;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= 4'd0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_we     <= 1'b0;
      lat_fault  <= 1'b0;
      owner_ls   <= 1'b0;
      if_rdata_q <= 32'h0;
      ls_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_ls  <= pick_ls;
            lat_addr  <= sel_addr;
            lat_wdata <= pick_ls ? bus.ls_wdata : 32'h0;
            lat_we    <= sel_we;
            lat_fault <= sel_fault;
            // A contested LS win can only occur below WAIT_MAX, so the increment saturates there.
            if (!pick_ls) begin
              wait_cnt <= 4'd0;
            end else if (bus.if_req && (wait_cnt < WAIT_MAX)) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        GRANT: begin
          if (owner_ls) begin
            ls_rdata_q <= grant_rdata;
          end else begin
            if_rdata_q <= grant_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A reset landing on the GRANT edge must never commit the write.
  always_comb begin
    bus.mem_A    = 32'h0;
    bus.mem_WD   = 32'h0;
    bus.mem_WE   = 1'b0;
    bus.if_ready = 1'b0;
    bus.if_err   = 1'b0;
    bus.if_rdata = 32'h0;
    bus.ls_ready = 1'b0;
    bus.ls_err   = 1'b0;
    bus.ls_rdata = 32'h0;
    busy         = (state != IDLE);
    case (state)
      GRANT: begin
        bus.mem_A  = lat_addr;
        bus.mem_WD = lat_wdata;
        bus.mem_WE = lat_we & ~lat_fault & ~rst;
      end
      RESP: begin
        if (owner_ls) begin
          bus.ls_ready = 1'b1;
          bus.ls_err   = lat_fault;
          bus.ls_rdata = ls_rdata_q;
        end else begin
          bus.if_ready = 1'b1;
          bus.if_err   = lat_fault;
          bus.if_rdata = if_rdata_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests push expected responses with their
// due cycle, and a negedge monitor pops and checks them as the ready pulses appear.
module tb_mem_arbiter;

  localparam int MEM_WORDS = 1000;
  localparam int DATA_BASE = 2000;
  localparam int MAX_WAIT  = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  mem_arbiter_if bus();

  mem_arbiter #(
    .MEM_WORDS(MEM_WORDS),
    .DATA_BASE(DATA_BASE),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int we_cnt = 0;
  logic [31:0] we_addr = 32'h0;
  int we_cyc = -1;

  exp_t if_q[$];
  exp_t ls_q[$];
  exp_t if_e;
  exp_t ls_e;

  // Memory model: preset contents on the first edge, then combinational read / posedge write.
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        init_done;
  logic [31:0] widx;

  assign widx = {2'b00, bus.mem_A[31:2]};

  always_comb begin
    bus.mem_RD = (widx < 32'(MEM_WORDS)) ? mem[widx[9:0]] : 32'h0;
  end

  always @(posedge clk) begin
    if (init_done !== 1'b1) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
      mem[2]    <= 32'h00500113;
      mem[3]    <= 32'h00A00193;
      mem[4]    <= 32'hCAFEF00D;
      mem[502]  <= 32'h12345678;
      mem[999]  <= 32'h0BADC0DE;
      init_done <= 1'b1;
    end else if (bus.mem_WE && (widx < 32'(MEM_WORDS))) begin
      mem[widx[9:0]] <= bus.mem_WD;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation on that port.
  always @(negedge clk) begin
    if (!rst && init_done === 1'b1) begin
      if (bus.mem_WE) begin
        we_cnt++;
        we_addr = bus.mem_A;
        we_cyc  = cyc;
      end
      if (bus.if_ready || bus.ls_ready) begin
        checkOutput("ready_exclusive", 32'(bus.if_ready & bus.ls_ready), 32'h0);
      end
      if (bus.if_ready) begin
        if (if_q.size() == 0) begin
          checkOutput("if_unexpected_ready", 32'h1, 32'h0);
        end else begin
          if_e = if_q.pop_front();
          checkOutput({if_e.tag, "_rdata"}, bus.if_rdata, if_e.rdata);
          checkOutput({if_e.tag, "_err"}, 32'(bus.if_err), 32'(if_e.err));
          checkOutput({if_e.tag, "_cycle"}, 32'(cyc), 32'(if_e.cyc));
        end
      end else begin
        checkOutput("if_quiet", 32'(bus.if_err || (bus.if_rdata != 32'h0)), 32'h0);
        if (if_q.size() != 0 && if_q[0].cyc < cyc) begin
          if_e = if_q.pop_front();
          checkOutput({if_e.tag, "_missing"}, 32'h0, 32'h1);
        end
      end
      if (bus.ls_ready) begin
        if (ls_q.size() == 0) begin
          checkOutput("ls_unexpected_ready", 32'h1, 32'h0);
        end else begin
          ls_e = ls_q.pop_front();
          checkOutput({ls_e.tag, "_rdata"}, bus.ls_rdata, ls_e.rdata);
          checkOutput({ls_e.tag, "_err"}, 32'(bus.ls_err), 32'(ls_e.err));
          checkOutput({ls_e.tag, "_cycle"}, 32'(cyc), 32'(ls_e.cyc));
        end
      end else begin
        checkOutput("ls_quiet", 32'(bus.ls_err || (bus.ls_rdata != 32'h0)), 32'h0);
        if (ls_q.size() != 0 && ls_q[0].cyc < cyc) begin
          ls_e = ls_q.pop_front();
          checkOutput({ls_e.tag, "_missing"}, 32'h0, 32'h1);
        end
      end
    end
  end

  task automatic nextCycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raises a request, records its expected response, waits (bounded) for ready.
  task automatic applyStimulus(input bit is_ls, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input bit exp_err, input int exp_cyc, input bit hold,
                               input string tag);
    exp_t e;
    bit   seen;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = exp_cyc;
    e.tag   = tag;
    if (is_ls) begin
      bus.ls_req   = 1'b1;
      bus.ls_we    = we;
      bus.ls_addr  = addr;
      bus.ls_wdata = wdata;
      ls_q.push_back(e);
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
      if_q.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = is_ls ? bus.ls_ready : bus.if_ready;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
    if (!hold) begin
      if (is_ls) bus.ls_req = 1'b0;
      else       bus.if_req = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_flags"},
                {26'h0, bus.if_ready, bus.if_err, bus.ls_ready, bus.ls_err, bus.mem_WE, busy}, 32'h0);
    checkOutput({name, "_if_rdata"}, bus.if_rdata, 32'h0);
    checkOutput({name, "_ls_rdata"}, bus.ls_rdata, 32'h0);
    checkOutput({name, "_mem_A"}, bus.mem_A, 32'h0);
    checkOutput({name, "_mem_WD"}, bus.mem_WD, 32'h0);
  endtask

  initial begin
    int c;
    int we0;

    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = 32'h0;
    bus.ls_wdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    nextCycle(1);

    // Plain fetch: response two cycles after the IDLE sample, never a write.
    c = cyc; we0 = we_cnt;
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0, 32'h00500113, 1'b0, c + 2, 1'b0, "if_fetch");
    checkOutput("if_fetch_no_write", 32'(we_cnt), 32'(we0));
    nextCycle(2);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Store then load back in the data region.
    c = cyc; we0 = we_cnt;
    applyStimulus(1'b1, 1'b1, 32'd2004, 32'hDEADBEEF, 32'h0, 1'b0, c + 2, 1'b0, "ls_store");
    checkOutput("store_we_count", 32'(we_cnt), 32'(we0 + 1));
    checkOutput("store_we_addr", we_addr, 32'd2004);
    checkOutput("store_we_cycle", 32'(we_cyc), 32'(c + 1));
    checkOutput("store_mem501", mem[501], 32'hDEADBEEF);
    nextCycle(1);
    c = cyc;
    applyStimulus(1'b1, 1'b0, 32'd2004, 32'h0, 32'hDEADBEEF, 1'b0, c + 2, 1'b0, "ls_load");
    nextCycle(1);

    // Region boundaries: first data word is writable, last memory word is readable.
    c = cyc; we0 = we_cnt;
    applyStimulus(1'b1, 1'b1, 32'd2000, 32'h11111111, 32'h0, 1'b0, c + 2, 1'b0, "ls_store_base");
    checkOutput("store_base_we_count", 32'(we_cnt), 32'(we0 + 1));
    nextCycle(1);
    c = cyc;
    applyStimulus(1'b1, 1'b0, 32'd3996, 32'h0, 32'h0BADC0DE, 1'b0, c + 2, 1'b0, "ls_load_last");
    nextCycle(1);

    // Faults: protected store, misaligned load, out-of-range fetch.
    we0 = we_cnt;
    c = cyc;
    applyStimulus(1'b1, 1'b1, 32'h10, 32'h55555555, 32'h0, 1'b1, c + 2, 1'b0, "fault_store_low");
    nextCycle(1);
    c = cyc;
    applyStimulus(1'b1, 1'b0, 32'd2002, 32'h0, 32'h0, 1'b1, c + 2, 1'b0, "fault_misaligned");
    nextCycle(1);
    c = cyc;
    applyStimulus(1'b0, 1'b0, 32'd4000, 32'h0, 32'h0, 1'b1, c + 2, 1'b0, "fault_range");
    checkOutput("fault_no_write", 32'(we_cnt), 32'(we0));
    checkOutput("fault_mem4", mem[4], 32'hCAFEF00D);
    nextCycle(1);

    // Both held continuously: LS x4, then IF forced, then LS resumes.
    c = cyc;
    fork
      begin
        applyStimulus(1'b1, 1'b0, 32'd2004, 32'h0, 32'hDEADBEEF, 1'b0, c + 2,  1'b1, "cont_ls0");
        applyStimulus(1'b1, 1'b0, 32'd3996, 32'h0, 32'h0BADC0DE, 1'b0, c + 5,  1'b1, "cont_ls1");
        applyStimulus(1'b1, 1'b0, 32'd2000, 32'h0, 32'h11111111, 1'b0, c + 8,  1'b1, "cont_ls2");
        applyStimulus(1'b1, 1'b0, 32'd2004, 32'h0, 32'hDEADBEEF, 1'b0, c + 11, 1'b1, "cont_ls3");
        applyStimulus(1'b1, 1'b0, 32'd3996, 32'h0, 32'h0BADC0DE, 1'b0, c + 17, 1'b1, "cont_ls4");
        applyStimulus(1'b1, 1'b0, 32'd2000, 32'h0, 32'h11111111, 1'b0, c + 20, 1'b0, "cont_ls5");
      end
      begin
        applyStimulus(1'b0, 1'b0, 32'h8, 32'h0, 32'h00500113, 1'b0, c + 14, 1'b0, "cont_if");
      end
    join
    nextCycle(1);

    // Simultaneous first requests with a cleared wait counter.
    c = cyc;
    fork
      applyStimulus(1'b1, 1'b0, 32'd2004, 32'h0, 32'hDEADBEEF, 1'b0, c + 2, 1'b0, "sim_ls");
      applyStimulus(1'b0, 1'b0, 32'hC, 32'h0, 32'h00A00193, 1'b0, c + 5, 1'b0, "sim_if");
    join
    nextCycle(1);

    // Reset during the GRANT cycle of a store aborts it.
    we0 = we_cnt;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'd2008;
    bus.ls_wdata = 32'hA5A5A5A5;
    nextCycle(1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_A", bus.mem_A, 32'd2008);
    checkOutput("abort_mem_WE", 32'(bus.mem_WE), 32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.ls_req = 1'b0;
    @(negedge clk);
    checkAllZero("abort_after");
    nextCycle(4);
    checkOutput("abort_mem502", mem[502], 32'h12345678);
    checkOutput("abort_no_write", 32'(we_cnt), 32'(we0));

    nextCycle(4);
    checkOutput("if_queue_drained", 32'(if_q.size()), 32'h0);
    checkOutput("ls_queue_drained", 32'(ls_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
